// File: rtl/ecc_ctrl_pkg.sv
// Shared types, defaults and helpers for the ECC job sequencer.
package ecc_ctrl_pkg;

  localparam int TIMEOUT_DEF    = 'h00FF_FFFF;
  localparam int RST_CYCLES_DEF = 4;
  localparam int WD_W           = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_BUSY    = 3'd2,
    ST_RECOVER = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  // Number of bits needed to index n items (n >= 2).
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_arbiter
  import ecc_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2_f(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_grant_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o
);

  int             sum;
  logic [IDW-1:0] sel;
  logic           found;

  // Scan last_grant+1 .. last_grant and grant the first active request.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    sum       = 0;
    sel       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = int'(last_grant_i) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      sel = IDW'(sum);
      if (en_i && !found && req_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        gnt_idx_o  = sel;
      end
    end
  end

endmodule

// File: rtl/ecc_job_arbiter.sv
// Shares one scalar-multiplication core between NREQ requesters, one job at a
// time, returning ID-tagged results and recovering the core if it hangs.
//
// state   | meaning
// IDLE    | waiting for a request (and for any stale core_done to drop)
// ISSUE   | one-cycle core_start pulse, watchdog cleared
// BUSY    | waiting for core_done rising edge, watchdog counting
// RECOVER | core held in reset after a watchdog timeout
// RESP    | result presented until rsp_ready
module ecc_job_arbiter
  import ecc_ctrl_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int KEY_W      = 256,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int IDW        = clog2_f(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*KEY_W-1:0] req_key,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [KEY_W-1:0]      rsp_x,
  output logic [KEY_W-1:0]      rsp_y,
  output logic                  rsp_err,
  output logic                  core_rst,
  output logic                  core_start,
  output logic [KEY_W-1:0]      core_priv_key,
  input  logic [KEY_W-1:0]      core_pub_x,
  input  logic [KEY_W-1:0]      core_pub_y,
  input  logic                  core_done,
  output logic                  busy
);

  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] RST_LAST = WD_W'(RST_CYCLES - 1);

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] x_q, x_d;
  logic [KEY_W-1:0] y_q, y_d;
  logic             err_q, err_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             done_prev_q;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             arb_en;
  logic             done_rise;

  // A stale done from the previous job blocks new grants until it drops.
  assign arb_en    = rst_n && (state_q == ST_IDLE) && !core_done;
  assign done_rise = core_done && !done_prev_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .en_i         (arb_en),
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx)
  );

  assign req_ready     = gnt;
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_id        = id_q;
  assign rsp_x         = x_q;
  assign rsp_y         = y_q;
  assign rsp_err       = err_q;
  assign core_rst      = !rst_n || (state_q == ST_RECOVER);
  assign core_start    = (state_q == ST_ISSUE);
  assign core_priv_key = key_q;
  assign busy          = (state_q != ST_IDLE);

  // Next-state and datapath capture; the watchdog doubles as the recovery timer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    key_d        = key_q;
    x_d          = x_q;
    y_d          = y_q;
    err_d        = err_q;
    wdog_d       = wdog_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          key_d        = req_key[int'(gnt_idx)*KEY_W +: KEY_W];
          id_d         = gnt_idx;
          last_grant_d = gnt_idx;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (done_rise) begin
          x_d     = core_pub_x;
          y_d     = core_pub_y;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wdog_q == WD_LAST) begin
          x_d     = '0;
          y_d     = '0;
          err_d   = 1'b1;
          wdog_d  = '0;
          state_d = ST_RECOVER;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_RECOVER: begin
        if (wdog_q == RST_LAST) state_d = ST_RESP;
        else                    wdog_d  = wdog_q + WD_W'(1);
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and capture registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
      key_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      err_q        <= 1'b0;
      wdog_q       <= '0;
      done_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      key_q        <= key_d;
      x_q          <= x_d;
      y_q          <= y_d;
      err_q        <= err_d;
      wdog_q       <= wdog_d;
      done_prev_q  <= core_done;
    end
  end

endmodule

// File: tb/tb_ecc_job_arbiter.sv
// Directed bench for ecc_job_arbiter with a behavioural core and a response scoreboard.
module tb_ecc_job_arbiter;

  localparam int NREQ  = 4;
  localparam int KEY_W = 256;
  localparam int TO    = 64;
  localparam int RC    = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*KEY_W-1:0] req_key;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [KEY_W-1:0]      rsp_x, rsp_y;
  logic                  rsp_err;
  logic                  core_rst, core_start;
  logic [KEY_W-1:0]      core_priv_key;
  logic [KEY_W-1:0]      core_pub_x, core_pub_y;
  logic                  core_done;
  logic                  busy;

  ecc_job_arbiter #(
    .NREQ(NREQ), .KEY_W(KEY_W), .TIMEOUT(TO), .RST_CYCLES(RC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .core_rst(core_rst), .core_start(core_start), .core_priv_key(core_priv_key),
    .core_pub_x(core_pub_x), .core_pub_y(core_pub_y), .core_done(core_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       id;
    logic [KEY_W-1:0] x;
    logic [KEY_W-1:0] y;
    logic             err;
  } rsp_t;

  rsp_t             sb[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic [1:0]       cur_id;
  logic [KEY_W-1:0] cur_key;
  logic [KEY_W-1:0] keys [NREQ];

  function automatic logic [KEY_W-1:0] mx(input logic [KEY_W-1:0] k);
    return k ^ {4{64'hA5A5_5A5A_0F0F_F0F0}};
  endfunction

  function automatic logic [KEY_W-1:0] my(input logic [KEY_W-1:0] k);
    return {k[127:0], k[255:128]};
  endfunction

  task automatic chk(input string tag, input logic [KEY_W-1:0] obs, input logic [KEY_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for requester r's grant, take the handshake, check the issued job.
  task automatic grant(input int r, input logic [KEY_W-1:0] key, input string tag,
                       input bit drop, output int waited);
    #1;
    waited = 0;
    while (req_ready == '0 && waited < 200) begin
      tick();
      waited++;
    end
    chk({tag, "_ready"}, req_ready, 256'(1) << r);
    cur_id  = 2'(r);
    cur_key = key;
    tick();
    if (drop) req_valid[r] = 1'b0;
    chk({tag, "_start"}, core_start, 1);
    chk({tag, "_key"}, core_priv_key, key);
    chk({tag, "_ready_off"}, req_ready, 0);
  endtask

  // Behavioural core: done d cycles after the start pulse.
  task automatic serve(input int d, input bit keep_done);
    for (int i = 1; i <= d; i++) begin
      tick();
      if (i == 1) begin
        chk("start_pulse", core_start, 0);
        chk("busy", busy, 1);
      end
      if (i == d) chk("early_rsp", rsp_valid, 0);
    end
    core_done  = 1'b1;
    core_pub_x = mx(cur_key);
    core_pub_y = my(cur_key);
    sb.push_back('{cur_id, mx(cur_key), my(cur_key), 1'b0});
    tick();
    chk("rsp_latency", rsp_valid, 1);
    chk("rsp_no_rst", core_rst, 0);
    if (!keep_done) core_done = 1'b0;
  endtask

  task automatic take_rsp(input string tag);
    rsp_t e;
    int   w;
    w = 0;
    while (!rsp_valid && w < 300) begin
      tick();
      w++;
    end
    chk({tag, "_valid"}, rsp_valid, 1);
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.id = 'x; e.x = 'x; e.y = 'x; e.err = 'x;
    end
    chk({tag, "_id"}, rsp_id, e.id);
    chk({tag, "_x"}, rsp_x, e.x);
    chk({tag, "_y"}, rsp_y, e.y);
    chk({tag, "_err"}, rsp_err, e.err);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, rsp_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int               w, lg, er, first, cnt;
    logic [KEY_W-1:0] k;

    rst_n = 1'b0; req_valid = '0; req_key = '0; rsp_ready = 1'b0;
    core_done = 1'b0; core_pub_x = '0; core_pub_y = '0;
    for (int i = 0; i < NREQ; i++)
      keys[i] = {4{64'h0123_4567_89AB_CDEF}} ^ (256'(i + 1) << (i * 40));

    // Reset values
    #1;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_rsp_x", rsp_x, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_key", core_priv_key, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rel_core_rst", core_rst, 0);

    // Single request from requester 2, key 2^71, done after 50 cycles
    k = 256'(1) << 71;
    req_key[2*KEY_W +: KEY_W] = k;
    req_valid[2] = 1'b1;
    grant(2, k, "single", 1, w);
    chk("single_wait", w, 0);
    serve(50, 0);
    take_rsp("single");
    lg = 2;

    // Fairness with all requesters continuously valid; back-pressure on job 2
    for (int i = 0; i < NREQ; i++) req_key[i*KEY_W +: KEY_W] = keys[i];
    req_valid = '1;
    for (int j = 0; j < 8; j++) begin
      er = (lg + 1) % NREQ;
      grant(er, keys[er], "fair", 0, w);
      chk("fair_wait", w, 0);
      serve(5 + j, 0);
      if (j == 2) begin
        for (int i = 0; i < 100; i++) begin
          tick();
          chk("bp_ready", req_ready, 0);
          chk("bp_start", core_start, 0);
          chk("bp_valid", rsp_valid, 1);
          chk("bp_x", rsp_x, sb[0].x);
          chk("bp_id", rsp_id, sb[0].id);
        end
      end
      take_rsp("fair");
      lg = er;
    end
    req_valid = '0;

    // Hang: core never signals done
    req_valid[1] = 1'b1;
    grant(1, keys[1], "hang", 1, w);
    sb.push_back('{2'd1, 256'd0, 256'd0, 1'b1});
    first = 0; cnt = 0;
    for (int i = 1; i <= TO + RC + 1; i++) begin
      tick();
      if (core_rst) begin
        cnt++;
        if (first == 0) first = i;
      end
      if (i == TO + RC) chk("hang_early_rsp", rsp_valid, 0);
    end
    chk("hang_rst_first", first, TO + 1);
    chk("hang_rst_len", cnt, RC);
    chk("hang_rsp_at", rsp_valid, 1);
    take_rsp("hang");

    // Next job after recovery proceeds normally
    req_valid[0] = 1'b1;
    grant(0, keys[0], "after_hang", 1, w);
    serve(10, 0);
    take_rsp("after_hang");

    // Stale done held into IDLE blocks the next grant
    req_valid[3] = 1'b1;
    grant(3, keys[3], "stale1", 1, w);
    serve(20, 1);
    take_rsp("stale1");
    req_valid[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stale_ready", req_ready, 0);
      chk("stale_start", core_start, 0);
    end
    core_done = 1'b0;
    grant(2, keys[2], "stale2", 1, w);
    chk("stale2_wait", w, 0);
    serve(15, 0);
    take_rsp("stale2");

    // Done arriving in the same cycle as the timeout wins
    req_valid[1] = 1'b1;
    grant(1, keys[1], "coinc", 1, w);
    serve(TO, 0);
    take_rsp("coinc");

    // Async reset in BUSY abandons the job; first grant afterwards goes to 0
    req_valid[2] = 1'b1;
    grant(2, keys[2], "abort", 0, w);
    req_valid = '1;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_core_rst", core_rst, 1);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_start", core_start, 0);
    chk("arst_key", core_priv_key, 0);
    chk("arst_id", rsp_id, 0);
    core_done = 1'b1; core_pub_x = mx(keys[2]); core_pub_y = my(keys[2]);
    repeat (2) tick();
    core_done = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 chk("arst_no_rsp", rsp_valid, 0);
    grant(0, keys[0], "post_rst", 0, w);
    chk("post_rst_wait", w, 0);
    req_valid = '0;
    serve(8, 0);
    take_rsp("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
